// File: rtl/fetch_seq_ctrl_if.sv
// Fetch sequencer bus interface: groups the i-MMU translate and icache read
// handshakes. The master modport is the sequencer side; slave is the MMU/icache side.
interface fetch_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mmu_req_o;
    logic [XLEN-1:0] mmu_vaddr_o;
    logic            mmu_hit_i;
    logic [XLEN-1:0] mmu_paddr_i;
    logic            mmu_fault_i;
    logic            icache_req_o;
    logic [XLEN-1:0] icache_addr_o;
    logic            icache_ack_i;

    modport master (
        output mmu_req_o,
        output mmu_vaddr_o,
        input  mmu_hit_i,
        input  mmu_paddr_i,
        input  mmu_fault_i,
        output icache_req_o,
        output icache_addr_o,
        input  icache_ack_i
    );

    modport slave (
        input  mmu_req_o,
        input  mmu_vaddr_o,
        output mmu_hit_i,
        output mmu_paddr_i,
        output mmu_fault_i,
        input  icache_req_o,
        input  icache_addr_o,
        output icache_ack_i
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Instruction prefetch sequencer: owns the fetch address, runs one
// translate + icache read at a time and tracks prefetch FIFO occupancy.
// Optional build macro FETCH_SEQ_PERF_EN adds saturating drop/stall counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no request; waits for fetch_en_i and FIFO space
// XLATE  | translation requested for the current fetch address
// REQ    | icache read of the latched physical address outstanding
// DRAIN  | redirected while reading; the pending ack is swallowed
// FAULT  | translation faulted; parked until a redirect
module fetch_seq_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    localparam int             OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en_i,
    input  logic                 redirect_i,
    input  logic [XLEN-1:0]      redirect_pc_i,
    input  logic                 pop_i,
    fetch_seq_ctrl_if.master     bus,
    output logic                 push_o,
    output logic [OCC_W-1:0]     occ_o,
    output logic                 fault_o,
    output logic                 busy_o
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]          drop_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_XLATE = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [XLEN-1:0]  RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [OCC_W-1:0] DEPTH_C    = OCC_W'(FIFO_DEPTH);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [XLEN-1:0]  r_fetch_addr;
    logic [XLEN-1:0]  w_fetch_addr_next;
    logic [XLEN-1:0]  r_paddr;
    logic [XLEN-1:0]  w_redirect_addr;
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_ack;
    logic             w_push;
    logic             w_pop_eff;
    logic             w_space;
    logic             w_drop;
    logic             w_unused_pc_lsbs;

    assign w_ack            = bus.icache_ack_i;
    assign w_redirect_addr  = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];

    // A word is pushed only when a live read is acked; a coincident redirect makes it stale.
    assign w_push    = (r_state == S_REQ) && w_ack && !redirect_i;
    assign w_drop    = w_ack && ((r_state == S_DRAIN) || ((r_state == S_REQ) && redirect_i));
    assign w_pop_eff = pop_i && (r_occ != '0);
    assign w_space   = (w_occ_next < DEPTH_C);

    // Occupancy: push/pop net out, pops on empty are ignored, redirect empties the FIFO.
    always_comb begin
        w_occ_next = r_occ;
        if (redirect_i) begin
            w_occ_next = '0;
        end else if (w_push && !w_pop_eff) begin
            w_occ_next = r_occ + OCC_W'(1);
        end else if (!w_push && w_pop_eff) begin
            w_occ_next = r_occ - OCC_W'(1);
        end
    end

    // Fetch address: redirect reloads it aligned, each pushed word advances it (wrapping).
    always_comb begin
        w_fetch_addr_next = r_fetch_addr;
        if (redirect_i) begin
            w_fetch_addr_next = w_redirect_addr;
        end else if (w_push) begin
            w_fetch_addr_next = r_fetch_addr + XLEN'(4);
        end
    end

    // Next-state logic; redirect never abandons an outstanding icache request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (fetch_en_i && w_space && !redirect_i) begin
                    w_state_next = S_XLATE;
                end
            end
            S_XLATE: begin
                if (redirect_i) begin
                    w_state_next = S_IDLE;
                end else if (bus.mmu_fault_i) begin
                    w_state_next = S_FAULT;
                end else if (bus.mmu_hit_i) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    w_state_next = w_ack ? S_XLATE : S_DRAIN;
                end else if (w_ack) begin
                    w_state_next = (fetch_en_i && w_space) ? S_XLATE : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_ack) begin
                    w_state_next = (redirect_i || fetch_en_i) ? S_XLATE : S_IDLE;
                end
            end
            S_FAULT: begin
                if (redirect_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, address, occupancy and translated-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= RESET_ADDR;
            r_occ        <= '0;
            r_paddr      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_occ        <= w_occ_next;
            if ((r_state == S_XLATE) && bus.mmu_hit_i && !bus.mmu_fault_i && !redirect_i) begin
                r_paddr <= bus.mmu_paddr_i;
            end
        end
    end

    assign bus.mmu_req_o     = (r_state == S_XLATE);
    assign bus.mmu_vaddr_o   = (r_state == S_XLATE) ? r_fetch_addr : '0;
    assign bus.icache_req_o  = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign bus.icache_addr_o = r_paddr;
    assign push_o            = w_push;
    assign occ_o             = r_occ;
    assign fault_o           = (r_state == S_FAULT);
    assign busy_o            = (r_state != S_IDLE);

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] r_drop_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (fetch_en_i && !w_space && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign drop_cnt_o  = r_drop_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl (XLEN=32, FIFO_DEPTH=2, RESET_PC=0).
module tb_fetch_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pop;
    logic        push;
    logic [1:0]  occ;
    logic        fault;
    logic        busy;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] drop_cnt;
    logic [31:0] stall_cnt;
`endif
    int total = 0;
    int bad   = 0;

    logic [31:0] s_vaddr;
    logic [31:0] s_iaddr;
    logic        s_push;

    fetch_seq_ctrl_if #(.XLEN(32)) bus ();

    fetch_seq_ctrl #(
        .XLEN(32),
        .FIFO_DEPTH(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en_i(fetch_en),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .pop_i(pop),
        .bus(bus),
        .push_o(push),
        .occ_o(occ),
        .fault_o(fault),
        .busy_o(busy)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .drop_cnt_o(drop_cnt),
        .stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays MMU and icache: hit one cycle after the request, ack one cycle after the read.
    task automatic serve_txn(input logic [31:0] paddr, input bit pop_at_ack,
                             output logic [31:0] seen_vaddr, output logic [31:0] seen_iaddr,
                             output logic seen_push);
        int n;
        seen_vaddr = 'x;
        seen_iaddr = 'x;
        seen_push  = 1'bx;
        n = 0;
        while (!bus.mmu_req_o && n < 20) begin
            tick();
            n++;
        end
        if (!bus.mmu_req_o) return;
        seen_vaddr = bus.mmu_vaddr_o;
        tick();
        bus.mmu_hit_i   = 1'b1;
        bus.mmu_paddr_i = paddr;
        tick();
        bus.mmu_hit_i   = 1'b0;
        bus.mmu_paddr_i = '0;
        n = 0;
        while (!bus.icache_req_o && n < 20) begin
            tick();
            n++;
        end
        if (!bus.icache_req_o) return;
        seen_iaddr = bus.icache_addr_o;
        tick();
        bus.icache_ack_i = 1'b1;
        pop = pop_at_ack;
        #1;
        seen_push = push;
        tick();
        bus.icache_ack_i = 1'b0;
        pop = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; pop = 1'b0;
        bus.mmu_hit_i = 1'b0; bus.mmu_paddr_i = '0; bus.mmu_fault_i = 1'b0; bus.icache_ack_i = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0 || bus.mmu_req_o !== 1'b0 || bus.icache_req_o !== 1'b0) begin
            bad++; $display("FAIL reset_req busy=%b mmu_req=%b ic_req=%b want 0 0 0", busy, bus.mmu_req_o, bus.icache_req_o); end
        total++; if (occ !== 2'd0 || push !== 1'b0 || fault !== 1'b0) begin
            bad++; $display("FAIL reset_flags occ=%0d push=%b fault=%b want 0 0 0", occ, push, fault); end
        total++; if (bus.mmu_vaddr_o !== 32'h0 || bus.icache_addr_o !== 32'h0) begin
            bad++; $display("FAIL reset_addr vaddr=%h iaddr=%h want 0 0", bus.mmu_vaddr_o, bus.icache_addr_o); end
    endtask

    task automatic test_fetch();
        rst = 1'b0;
        fetch_en = 1'b1;
        serve_txn(32'h8000_0000, 1'b0, s_vaddr, s_iaddr, s_push);
        total++; if (s_vaddr !== 32'h0) begin bad++; $display("FAIL fetch0_vaddr got=%h want=%h", s_vaddr, 32'h0); end
        total++; if (s_iaddr !== 32'h8000_0000) begin bad++; $display("FAIL fetch0_iaddr got=%h want=%h", s_iaddr, 32'h8000_0000); end
        total++; if (s_push !== 1'b1) begin bad++; $display("FAIL fetch0_push got=%b want=1", s_push); end
        total++; if (occ !== 2'd1) begin bad++; $display("FAIL fetch0_occ got=%0d want=1", occ); end
        serve_txn(32'h8000_0004, 1'b0, s_vaddr, s_iaddr, s_push);
        total++; if (s_vaddr !== 32'h4 || s_push !== 1'b1) begin
            bad++; $display("FAIL fetch1 vaddr=%h push=%b want 4 1", s_vaddr, s_push); end
        total++; if (occ !== 2'd2 || busy !== 1'b0) begin
            bad++; $display("FAIL fetch_full occ=%0d busy=%b want 2 0", occ, busy); end
        tick(); tick(); tick();
        total++; if (bus.mmu_req_o !== 1'b0 || busy !== 1'b0 || occ !== 2'd2) begin
            bad++; $display("FAIL fetch_hold mmu_req=%b busy=%b occ=%0d want 0 0 2", bus.mmu_req_o, busy, occ); end
    endtask

    task automatic test_pop();
        pop = 1'b1; #1; tick(); pop = 1'b0;
        total++; if (occ !== 2'd1 || bus.mmu_req_o !== 1'b1) begin
            bad++; $display("FAIL pop_start occ=%0d mmu_req=%b want 1 1", occ, bus.mmu_req_o); end
        serve_txn(32'h8000_0008, 1'b0, s_vaddr, s_iaddr, s_push);
        total++; if (s_vaddr !== 32'h8 || s_push !== 1'b1) begin
            bad++; $display("FAIL pop_txn vaddr=%h push=%b want 8 1", s_vaddr, s_push); end
        total++; if (occ !== 2'd2 || busy !== 1'b0) begin
            bad++; $display("FAIL pop_refill occ=%0d busy=%b want 2 0", occ, busy); end
        pop = 1'b1; #1; tick(); pop = 1'b0;
        serve_txn(32'h8000_000C, 1'b1, s_vaddr, s_iaddr, s_push);
        total++; if (s_vaddr !== 32'hC || s_push !== 1'b1) begin
            bad++; $display("FAIL pushpop_txn vaddr=%h push=%b want c 1", s_vaddr, s_push); end
        total++; if (occ !== 2'd1 || bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h10) begin
            bad++; $display("FAIL pushpop_occ occ=%0d mmu_req=%b vaddr=%h want 1 1 10", occ, bus.mmu_req_o, bus.mmu_vaddr_o); end
        serve_txn(32'h8000_0010, 1'b0, s_vaddr, s_iaddr, s_push);
        total++; if (occ !== 2'd2 || busy !== 1'b0) begin
            bad++; $display("FAIL pop_end occ=%0d busy=%b want 2 0", occ, busy); end
    endtask

    task automatic test_redirect_drain();
        pop = 1'b1; #1; tick(); pop = 1'b0;
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h14) begin
            bad++; $display("FAIL drain_xlate mmu_req=%b vaddr=%h want 1 14", bus.mmu_req_o, bus.mmu_vaddr_o); end
        tick();
        bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h9000_0000;
        tick();
        bus.mmu_hit_i = 1'b0; bus.mmu_paddr_i = '0;
        redirect = 1'b1; redirect_pc = 32'h0000_1002;
        tick();
        redirect = 1'b0;
        total++; if (bus.icache_req_o !== 1'b1 || bus.mmu_req_o !== 1'b0 || occ !== 2'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL drain_enter ic_req=%b mmu_req=%b occ=%0d busy=%b want 1 0 0 1",
                            bus.icache_req_o, bus.mmu_req_o, occ, busy); end
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        bus.icache_ack_i = 1'b1;
        #1;
        total++; if (push !== 1'b0 || bus.icache_req_o !== 1'b1) begin
            bad++; $display("FAIL drain_ack push=%b ic_req=%b want 0 1", push, bus.icache_req_o); end
        tick();
        bus.icache_ack_i = 1'b0;
        #1;
        total++; if (occ !== 2'd0 || bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h1000) begin
            bad++; $display("FAIL drain_resume occ=%0d mmu_req=%b vaddr=%h want 0 1 1000", occ, bus.mmu_req_o, bus.mmu_vaddr_o); end
        serve_txn(32'hA000_0000, 1'b0, s_vaddr, s_iaddr, s_push);
        total++; if (s_vaddr !== 32'h1000 || s_iaddr !== 32'hA000_0000 || s_push !== 1'b1 || occ !== 2'd1) begin
            bad++; $display("FAIL drain_next vaddr=%h iaddr=%h push=%b occ=%0d want 1000 a0000000 1 1",
                            s_vaddr, s_iaddr, s_push, occ); end
    endtask

    task automatic test_redirect_ack();
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h1004) begin
            bad++; $display("FAIL rack_xlate mmu_req=%b vaddr=%h want 1 1004", bus.mmu_req_o, bus.mmu_vaddr_o); end
        tick();
        bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'hA000_0004;
        tick();
        bus.mmu_hit_i = 1'b0; bus.mmu_paddr_i = '0;
        tick();
        bus.icache_ack_i = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_2000;
        #1;
        total++; if (push !== 1'b0 || bus.icache_req_o !== 1'b1) begin
            bad++; $display("FAIL rack_push push=%b ic_req=%b want 0 1", push, bus.icache_req_o); end
        tick();
        bus.icache_ack_i = 1'b0; redirect = 1'b0;
        #1;
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h2000 || occ !== 2'd0 || bus.icache_req_o !== 1'b0) begin
            bad++; $display("FAIL rack_next mmu_req=%b vaddr=%h occ=%0d ic_req=%b want 1 2000 0 0",
                            bus.mmu_req_o, bus.mmu_vaddr_o, occ, bus.icache_req_o); end
    endtask

    task automatic test_fault();
        bus.mmu_hit_i = 1'b1; bus.mmu_fault_i = 1'b1; bus.mmu_paddr_i = 32'hBBBB_0000;
        tick();
        bus.mmu_hit_i = 1'b0; bus.mmu_fault_i = 1'b0; bus.mmu_paddr_i = '0;
        #1;
        total++; if (fault !== 1'b1 || bus.icache_req_o !== 1'b0 || bus.mmu_req_o !== 1'b0) begin
            bad++; $display("FAIL fault_enter fault=%b ic_req=%b mmu_req=%b want 1 0 0", fault, bus.icache_req_o, bus.mmu_req_o); end
        tick(); tick();
        total++; if (fault !== 1'b1 || bus.icache_req_o !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL fault_hold fault=%b ic_req=%b busy=%b want 1 0 1", fault, bus.icache_req_o, busy); end
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        total++; if (fault !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL fault_clear fault=%b busy=%b want 0 0", fault, busy); end
        tick();
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h200) begin
            bad++; $display("FAIL fault_resume mmu_req=%b vaddr=%h want 1 200", bus.mmu_req_o, bus.mmu_vaddr_o); end
        bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'hCCCC_0000;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        bus.mmu_hit_i = 1'b0; bus.mmu_paddr_i = '0; redirect = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bus.icache_req_o !== 1'b0 || bus.icache_addr_o !== 32'hA000_0004) begin
            bad++; $display("FAIL hit_ignored busy=%b ic_req=%b iaddr=%h want 0 0 a0000004",
                            busy, bus.icache_req_o, bus.icache_addr_o); end
        tick();
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL top_xlate mmu_req=%b vaddr=%h want 1 fffffffc", bus.mmu_req_o, bus.mmu_vaddr_o); end
    endtask

    task automatic test_wrap();
        serve_txn(32'h1234_5678, 1'b0, s_vaddr, s_iaddr, s_push);
        total++; if (s_vaddr !== 32'hFFFF_FFFC || s_push !== 1'b1) begin
            bad++; $display("FAIL wrap_txn vaddr=%h push=%b want fffffffc 1", s_vaddr, s_push); end
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h0 || occ !== 2'd1) begin
            bad++; $display("FAIL wrap_next mmu_req=%b vaddr=%h occ=%0d want 1 0 1", bus.mmu_req_o, bus.mmu_vaddr_o, occ); end
`ifdef FETCH_SEQ_PERF_EN
        total++; if (drop_cnt !== 32'd2) begin bad++; $display("FAIL drop_cnt got=%0d want=2", drop_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        tick();
        bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h5555_0000;
        tick();
        bus.mmu_hit_i = 1'b0; bus.mmu_paddr_i = '0;
        #1;
        total++; if (bus.icache_req_o !== 1'b1 || bus.icache_addr_o !== 32'h5555_0000) begin
            bad++; $display("FAIL pre_rst ic_req=%b iaddr=%h want 1 55550000", bus.icache_req_o, bus.icache_addr_o); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus.icache_req_o !== 1'b0 || busy !== 1'b0 || occ !== 2'd0 || bus.icache_addr_o !== 32'h0) begin
            bad++; $display("FAIL async_rst ic_req=%b busy=%b occ=%0d iaddr=%h want 0 0 0 0",
                            bus.icache_req_o, busy, occ, bus.icache_addr_o); end
`ifdef FETCH_SEQ_PERF_EN
        total++; if (drop_cnt !== 32'd0) begin bad++; $display("FAIL drop_cnt_rst got=%0d want=0", drop_cnt); end
`endif
        tick();
        rst = 1'b0;
        tick();
        total++; if (bus.mmu_req_o !== 1'b1 || bus.mmu_vaddr_o !== 32'h0) begin
            bad++; $display("FAIL post_rst mmu_req=%b vaddr=%h want 1 0", bus.mmu_req_o, bus.mmu_vaddr_o); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_pop();
        test_redirect_drain();
        test_redirect_ack();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
